// File: rtl/csc_pkg.sv
// Shared constants and types for the compressed-sparse-column row expander.
package csc_pkg;

  localparam int unsigned CSC_MAT_RANK = 256;
  localparam int unsigned CSC_DATA_W   = 32;
  localparam int unsigned CSC_MAX_NNZ  = 4;
  localparam int unsigned CSC_PTR_W    = 3;

  typedef enum logic {
    IDLE,
    STREAM
  } csc_state_e;

  // Number of stored entries encoded by the nnz4 flag.
  function automatic logic [CSC_PTR_W-1:0] csc_nnz_count(input logic nnz4);
    return nnz4 ? CSC_PTR_W'(4) : CSC_PTR_W'(2);
  endfunction

endpackage

// File: rtl/csc_idx_check.sv
// Strict-ordering check over the 2 or 4 active column indices of a compressed row.
module csc_idx_check
  import csc_pkg::*;
#(
  parameter int unsigned IDX_W = 8
) (
  input  logic             i_nnz4,
  input  logic [IDX_W-1:0] i_idx0,
  input  logic [IDX_W-1:0] i_idx1,
  input  logic [IDX_W-1:0] i_idx2,
  input  logic [IDX_W-1:0] i_idx3,
  output logic             o_err
);

  logic w_ord01;
  logic w_ord12;
  logic w_ord23;

  // Flag any non-increasing pair among the active entries.
  always_comb begin
    w_ord01 = i_idx0 < i_idx1;
    w_ord12 = i_idx1 < i_idx2;
    w_ord23 = i_idx2 < i_idx3;
    o_err   = !w_ord01 || (i_nnz4 && (!w_ord12 || !w_ord23));
  end

endmodule

// File: rtl/csc_row_expand.sv
// Expands one compressed row (2 or 4 nonzeros) into MAT_RANK dense beats, one per column.
module csc_row_expand
  import csc_pkg::*;
#(
  parameter int unsigned MAT_RANK = CSC_MAT_RANK,
  parameter int unsigned IDX_W    = $clog2(MAT_RANK)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic                  in_nnz4,
  input  logic [IDX_W-1:0]      in_idx0,
  input  logic [IDX_W-1:0]      in_idx1,
  input  logic [IDX_W-1:0]      in_idx2,
  input  logic [IDX_W-1:0]      in_idx3,
  input  logic [CSC_DATA_W-1:0] in_val_i0,
  input  logic [CSC_DATA_W-1:0] in_val_i1,
  input  logic [CSC_DATA_W-1:0] in_val_i2,
  input  logic [CSC_DATA_W-1:0] in_val_i3,
  input  logic [CSC_DATA_W-1:0] in_val_r0,
  input  logic [CSC_DATA_W-1:0] in_val_r1,
  input  logic [CSC_DATA_W-1:0] in_val_r2,
  input  logic [CSC_DATA_W-1:0] in_val_r3,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [IDX_W-1:0]      out_idx,
  output logic [CSC_DATA_W-1:0] out_val_i,
  output logic [CSC_DATA_W-1:0] out_val_r,
  output logic                  out_last,
  output logic                  err
);

  localparam logic [IDX_W-1:0] LastCol = IDX_W'(MAT_RANK - 1);

  csc_state_e r_state;
  csc_state_e w_state_d;

  logic [IDX_W-1:0]      r_col;
  logic [CSC_PTR_W-1:0]  r_ptr;
  logic [CSC_PTR_W-1:0]  r_cnt;
  logic [IDX_W-1:0]      r_idx   [CSC_MAX_NNZ];
  logic [CSC_DATA_W-1:0] r_val_r [CSC_MAX_NNZ];
  logic [CSC_DATA_W-1:0] r_val_i [CSC_MAX_NNZ];
  logic                  r_err;

  logic       w_accept;
  logic       w_beat;
  logic       w_last;
  logic       w_hit;
  logic [1:0] w_sel;
  logic       w_idx_err;

  csc_idx_check #(
    .IDX_W (IDX_W)
  ) u_idx_check (
    .i_nnz4 (in_nnz4),
    .i_idx0 (in_idx0),
    .i_idx1 (in_idx1),
    .i_idx2 (in_idx2),
    .i_idx3 (in_idx3),
    .o_err  (w_idx_err)
  );

  // Handshake decode, hit detection and next-state selection.
  always_comb begin
    w_state_d = r_state;
    w_accept  = (r_state == IDLE) && in_vld;
    w_beat    = (r_state == STREAM) && out_rdy;
    w_last    = (r_col == LastCol);
    w_sel     = r_ptr[1:0];
    // The pointer never passes count, so it only addresses an unread entry when below it.
    w_hit     = (r_ptr < r_cnt) && (r_idx[w_sel] == r_col);
    unique case (r_state)
      IDLE:    if (w_accept) w_state_d = STREAM;
      STREAM:  if (w_beat && w_last) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  // State register; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Row capture at accept, then column/pointer advance on each accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_ptr <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
      for (int k = 0; k < CSC_MAX_NNZ; k++) begin
        r_idx[k]   <= '0;
        r_val_r[k] <= '0;
        r_val_i[k] <= '0;
      end
    end else begin
      r_err <= w_accept && w_idx_err;
      if (w_accept) begin
        r_col      <= '0;
        r_ptr      <= '0;
        r_cnt      <= csc_nnz_count(in_nnz4);
        r_idx[0]   <= in_idx0;
        r_idx[1]   <= in_idx1;
        r_idx[2]   <= in_idx2;
        r_idx[3]   <= in_idx3;
        r_val_r[0] <= in_val_r0;
        r_val_r[1] <= in_val_r1;
        r_val_r[2] <= in_val_r2;
        r_val_r[3] <= in_val_r3;
        r_val_i[0] <= in_val_i0;
        r_val_i[1] <= in_val_i1;
        r_val_i[2] <= in_val_i2;
        r_val_i[3] <= in_val_i3;
      end else if (w_beat) begin
        // Column wraps to 0 after the last beat, leaving out_idx clean in IDLE.
        r_col <= r_col + IDX_W'(1);
        if (w_hit) begin
          r_ptr <= r_ptr + CSC_PTR_W'(1);
        end
      end
    end
  end

  // Outputs depend only on registered state, so they hold while out_rdy is low.
  always_comb begin
    in_rdy    = (r_state == IDLE);
    out_vld   = (r_state == STREAM);
    out_idx   = r_col;
    out_last  = (r_state == STREAM) && w_last;
    out_val_r = '0;
    out_val_i = '0;
    if ((r_state == STREAM) && w_hit) begin
      out_val_r = r_val_r[w_sel];
      out_val_i = r_val_i[w_sel];
    end
    err = r_err;
  end

endmodule

// File: doc/csc_row_expand.md
CSC_ROW_EXPAND -- requirements
Module: csc_row_expand

Interface
REQ-001 Parameter MAT_RANK, default 256: number of columns per row vector; power of two, at least 4.
REQ-002 Parameter IDX_W, default $clog2(MAT_RANK): column-index width.
REQ-003 Port clk, input, 1: single clock; all logic is rising-edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port in_vld, input, 1: the compressed row on the in_* inputs is valid.
REQ-006 Port in_rdy, output, 1: the block can accept a compressed row.
REQ-007 Port in_nnz4, input, 1: 1 means 4 nonzeros (entries 0-3); 0 means 2 nonzeros (entries 0-1, the z0==z1 case).
REQ-008 Ports in_idx0..in_idx3, input, IDX_W each: column index of each nonzero entry.
REQ-009 Ports in_val_i0..3 and in_val_r0..3, input, 32 each: imaginary and real parts of each entry, signed.
REQ-010 Port out_vld, output, 1: the dense beat on the out_* outputs is valid.
REQ-011 Port out_rdy, input, 1: the downstream consumer accepts the beat.
REQ-012 Port out_idx, output, IDX_W: column number of the current beat.
REQ-013 Ports out_val_i and out_val_r, output, 32 each: element value; zero at non-stored columns.
REQ-014 Port out_last, output, 1: high on the beat with column MAT_RANK-1.
REQ-015 Port err, output, 1: one-cycle pulse when an accepted row is malformed.

Function
REQ-016 The block SHALL have two states, IDLE and STREAM; in_rdy SHALL equal (state==IDLE).
REQ-017 When in_vld and in_rdy are both high, the block SHALL register the entry count, indices and values, clear the column counter and entry pointer to 0, and enter STREAM on the next cycle.
REQ-018 In STREAM, out_vld SHALL be 1; the first beat SHALL appear exactly one cycle after the accept.
REQ-019 out_idx SHALL equal the column counter.
REQ-020 A beat is a hit when ptr < count and stored idx[ptr] == column counter.
REQ-021 On a hit, out_val SHALL be stored val[ptr]; otherwise out_val SHALL be 0.
REQ-022 The column counter and pointer SHALL advance only when out_vld and out_rdy are both high; while out_rdy is low, every out_* signal SHALL hold stable.
REQ-023 On an accepted hit beat, ptr SHALL increment by 1; ptr saturates at count.
REQ-024 On the accepted beat with out_last high, the block SHALL return to IDLE; in_rdy SHALL be high the following cycle, with no extra beats.
REQ-025 Outputs are registered, so back-to-back rows have exactly one idle cycle between the last beat and the next first beat.
REQ-026 err SHALL pulse the cycle after accept if the active indices are not strictly increasing.
REQ-027 On a malformed row the stream SHALL still run to completion; entries the pointer cannot reach are never emitted.
REQ-028 Inputs are sampled only at accept; input changes during STREAM SHALL have no effect.
REQ-029 Entry values SHALL pass through unmodified: no scaling, rounding or sign change.

Reset
REQ-030 On rst, the block SHALL go to IDLE with in_rdy=1 and out_vld=0.
REQ-031 On rst, out_idx, out_val_i, out_val_r, out_last and err SHALL be 0, and the counter, pointer and stored entries SHALL be cleared.
REQ-032 rst during STREAM SHALL abort the row immediately, with no further beats; rst has priority over every handshake.

Structure
REQ-033 Package csc_pkg SHALL hold the default MAT_RANK, the data width 32 and the state enum {IDLE, STREAM}.
REQ-034 The block SHALL use one sub-module, csc_idx_check: combinational strict-ordering check over 2 or 4 indices, driving err.
REQ-035 Counter, pointer and state SHALL live in csc_row_expand; no RAM is used.

Verification (MAT_RANK=8)
REQ-036 nnz4=1, idx={1,3,5,7}, vals r={10,20,30,40}, i=0, out_rdy=1 -> 8 beats, r=0,10,0,20,0,30,0,40; out_last only on idx 7; first beat 1 cycle after accept.
REQ-037 nnz4=0, idx0=2, idx1=6, r={5,-5} -> r=5 at col 2, r=-5 at col 6, zero elsewhere; idx2/idx3 contents ignored.
REQ-038 out_rdy toggled 1,0,0,1 per cycle with the row from REQ-036 -> outputs held during stalls; still exactly 8 beats, in order.
REQ-039 Two rows offered back-to-back with in_vld held high -> second row accepted the cycle after out_last; exactly one gap cycle.
REQ-040 idx={0,4,4,7}, nnz4=1 -> err pulses once; beats carry val0 at col 0, val1 at col 4, zero at col 7.
REQ-041 rst asserted at beat 3 of a row -> next cycle out_vld=0 and in_rdy=1; a new row then streams correctly from col 0.
